// File: rtl/scan_shadow_reg_pkg.sv
// Shared definitions for the muxed-scan shadow register bank:
// scan mode encodings and the width helper for the shift counter.
package scan_shadow_reg_pkg;

    localparam logic SCAN_FUNC  = 1'b0;
    localparam logic SCAN_SHIFT = 1'b1;

    // Ceiling log2, used to size counters that must hold the value v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_shadow_reg_if.sv
// Bus bundle for scan_shadow_reg: functional/scan controls in, shadow word and scan status out.
interface scan_shadow_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             en;
    logic             sel;
    logic             td;
    logic             upd;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             sdone;

    modport master (
        output d, en, sel, td, upd,
        input  q, so, sdone
    );

    modport slave (
        input  d, en, sel, td, upd,
        output q, so, sdone
    );
endinterface

// File: rtl/scan_shadow_reg_mux_ff.sv
// One bit of the capture stage: mux-D flop choosing scan shift or enabled functional load,
// asynchronously forced to RV by an active-high reset.
module scan_shadow_reg_mux_ff
    import scan_shadow_reg_pkg::*;
#(
    parameter logic RV = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic td_i,
    input  logic sel_i,
    input  logic en_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // An unknown select yields an unknown bit rather than silently picking a path.
    always_comb begin
        q_d = q_q;
        case (sel_i)
            SCAN_SHIFT: q_d = td_i;
            SCAN_FUNC:  if (en_i) q_d = d_i;
            default:    q_d = 1'bx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RV;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/scan_shadow_reg.sv
// WIDTH-bit muxed-scan register bank with an optional shadow output stage, so trim/config
// words can be scanned in without disturbing Q until an explicit update.
module scan_shadow_reg
    import scan_shadow_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter bit               SHADOW    = 1'b1
) (
    input logic               clk,
    input logic               rst,
    scan_shadow_reg_if.slave  bus
);

    localparam int unsigned SCNT_W = clog2(WIDTH + 1);

    logic [WIDTH-1:0]  cap;
    logic [SCNT_W-1:0] scnt_q;
    logic [SCNT_W-1:0] scnt_d;
    logic              sdone_q;
    logic              sdone_d;

    // Capture stage: bit 0 takes TD, each higher bit takes its lower neighbour when shifting.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cap
        logic td_bit;
        if (i == 0) begin : g_first
            assign td_bit = bus.td;
        end else begin : g_rest
            assign td_bit = cap[i-1];
        end

        scan_shadow_reg_mux_ff #(
            .RV (RESET_VAL[i])
        ) u_ff (
            .clk   (clk),
            .rst   (rst),
            .d_i   (bus.d[i]),
            .td_i  (td_bit),
            .sel_i (bus.sel),
            .en_i  (bus.en),
            .q_o   (cap[i])
        );
    end

    // Consecutive-shift counter saturates at WIDTH so SDONE stays up during over-shifting.
    always_comb begin
        scnt_d = '0;
        if (bus.sel == SCAN_SHIFT) begin
            if (scnt_q == SCNT_W'(WIDTH)) begin
                scnt_d = scnt_q;
            end else begin
                scnt_d = scnt_q + SCNT_W'(1);
            end
        end
        sdone_d = (scnt_d == SCNT_W'(WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q  <= '0;
            sdone_q <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            sdone_q <= sdone_d;
        end
    end

    if (SHADOW) begin : g_shadow
        logic [WIDTH-1:0] q_q;
        logic [WIDTH-1:0] q_d;

        // Updates are refused during shifting so Q never shows a half-loaded word.
        always_comb begin
            q_d = q_q;
            if ((bus.sel == SCAN_FUNC) && bus.upd) begin
                q_d = cap;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_q <= RESET_VAL;
            end else begin
                q_q <= q_d;
            end
        end

        assign bus.q = q_q;
    end else begin : g_direct
        logic unused_upd;
        assign unused_upd = bus.upd;
        assign bus.q      = cap;
    end

    assign bus.so    = cap[WIDTH-1];
    assign bus.sdone = sdone_q;

endmodule
